// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues reads to a
// synchronous instruction memory, buffers returned words with their PCs in a
// DEPTH-entry prefetch queue and hands them to decode over valid/ready.
// Run control: IDLE -> RUN on start, RUN -> DONE on an accepted halt.
module fetch_queue_unit #(
  parameter int                  PC_WIDTH    = 12,
  parameter int                  INSTR_WIDTH = 9,
  parameter int                  DEPTH       = 4,
  parameter logic [PC_WIDTH-1:0] START_ADDR  = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       imem_req,
  output logic [PC_WIDTH-1:0]        imem_addr,
  input  logic [INSTR_WIDTH-1:0]     imem_data,
  output logic                       instr_valid,
  output logic [INSTR_WIDTH-1:0]     instr,
  output logic [PC_WIDTH-1:0]        instr_pc,
  input  logic                       instr_ready,
  input  logic                       redirect,
  input  logic [PC_WIDTH-1:0]        redirect_target,
  input  logic                       halt,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [OCC_W:0]      DEPTH_V = (OCC_W+1)'(DEPTH);
  localparam logic [PC_WIDTH-1:0] PC_ONE  = PC_WIDTH'(1);
  localparam logic [PTR_W-1:0]    PTR_ONE = PTR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [PC_WIDTH-1:0]     fetch_pc_q, fetch_pc_d;
  logic                    inflight_q, inflight_d;
  logic [PC_WIDTH-1:0]     inflight_pc_q, inflight_pc_d;
  logic                    done_q, done_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]        count_q, count_d;

  logic [INSTR_WIDTH-1:0]  q_instr_q [DEPTH];
  logic [PC_WIDTH-1:0]     q_pc_q    [DEPTH];

  logic                    run;
  logic                    nonempty;
  logic                    pop;
  logic                    accept_halt;
  logic [OCC_W:0]          demand;
  logic                    flush;
  logic                    issue;
  logic                    push;

  assign run         = (state_q == S_RUN);
  assign nonempty    = (count_q != '0);
  assign pop         = run & nonempty & instr_ready;
  assign accept_halt = pop & halt;
  // Entries the queue must still absorb: held ones plus the one returning,
  // less the one leaving this cycle. Issue only if a slot remains for it.
  assign demand      = {1'b0, count_q} + {{OCC_W{1'b0}}, inflight_q}
                     - {{OCC_W{1'b0}}, pop};

  // Run-control next state, fetch PC steering and issue/push/flush decisions.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    done_d     = done_q;
    flush      = 1'b0;
    issue      = 1'b0;
    push       = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_RUN;
          fetch_pc_d = START_ADDR;
          done_d     = 1'b0;
          flush      = 1'b1;
        end
      end
      S_RUN: begin
        if (accept_halt) begin
          // Halt outranks redirect; the returning word is dropped.
          state_d = S_DONE;
          done_d  = 1'b1;
          flush   = 1'b1;
        end else if (redirect) begin
          // The word returning now belongs to the wrong path: drop it.
          flush      = 1'b1;
          fetch_pc_d = redirect_target;
        end else begin
          push  = inflight_q;
          issue = (demand < DEPTH_V);
          if (issue) fetch_pc_d = fetch_pc_q + PC_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Queue pointer, occupancy and in-flight tracking.
  always_comb begin
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    inflight_d    = issue;
    inflight_pc_d = fetch_pc_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      fetch_pc_q    <= START_ADDR;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      done_q        <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      done_q        <= done_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Queue storage; contents are only observed through occupancy, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr_q[wr_ptr_q] <= imem_data;
      q_pc_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  assign imem_req    = issue;
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = run & nonempty;
  assign instr       = nonempty ? q_instr_q[rd_ptr_q] : '0;
  assign instr_pc    = nonempty ? q_pc_q[rd_ptr_q]    : '0;
  assign busy        = run;
  assign done        = done_q;
  assign occupancy   = count_q;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: a cycle table for start-up and back-pressure,
// hand-written sequences for redirect, PC wrap, halt and mid-run reset, and a
// scoreboard that checks every delivered instruction against issued requests.
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        reset, start, imem_req, instr_valid, instr_ready;
  logic        redirect, halt, busy, done;
  logic [11:0] imem_addr, instr_pc, redirect_target;
  logic [8:0]  imem_data, instr;
  logic [2:0]  occupancy;

  int checks = 0;
  int failures = 0;
  logic [11:0] sb[$];

  always #5 clk = ~clk;

  fetch_queue_unit dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect(redirect),
    .redirect_target(redirect_target), .halt(halt),
    .busy(busy), .done(done), .occupancy(occupancy)
  );

  function automatic logic [8:0] memf(input logic [11:0] a);
    logic [11:0] t;
    t = a + 12'h010;
    return t[8:0];
  endfunction

  // Instruction memory: data one cycle after the request, junk otherwise.
  always @(posedge clk) imem_data <= imem_req ? memf(imem_addr) : 9'h1EE;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: requests push their PC, accepted heads pop and compare.
  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready) begin
      if (sb.size() == 0) chk("sb_unexpected_pc", {20'h0, instr_pc}, 32'hFFFFFFFF);
      else begin
        logic [11:0] p;
        p = sb.pop_front();
        chk("sb_pc", {20'h0, instr_pc}, {20'h0, p});
        chk("sb_instr", {23'h0, instr}, {23'h0, memf(p)});
      end
    end
    if (reset || (busy && (redirect || (instr_valid && instr_ready && halt))) || (start && !busy))
      sb.delete();
    if (imem_req && !reset) sb.push_back(imem_addr);
  end

  typedef struct {
    logic       st, rdy, req;
    logic [11:0] addr;
    logic       vld;
    logic [8:0] ins;
    logic [11:0] pc;
    logic       bsy;
    logic [2:0] occ;
  } vec_t;
  vec_t vt[15];

  function automatic vec_t mk(logic st, logic rdy, logic req, logic [11:0] addr,
                              logic vld, logic [8:0] ins, logic [11:0] pc,
                              logic bsy, logic [2:0] occ);
    vec_t v;
    v.st = st; v.rdy = rdy; v.req = req; v.addr = addr; v.vld = vld;
    v.ins = ins; v.pc = pc; v.bsy = bsy; v.occ = occ;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          st rdy req addr    vld ins     pc      bsy occ
    vt[0]  = mk(1, 1, 0, 12'h000, 0, 9'h000, 12'h000, 0, 0);
    vt[1]  = mk(0, 1, 1, 12'h000, 0, 9'h000, 12'h000, 1, 0);
    vt[2]  = mk(0, 1, 1, 12'h001, 0, 9'h000, 12'h000, 1, 0);
    vt[3]  = mk(0, 1, 1, 12'h002, 1, 9'h010, 12'h000, 1, 1);
    vt[4]  = mk(0, 1, 1, 12'h003, 1, 9'h011, 12'h001, 1, 1);
    vt[5]  = mk(0, 1, 1, 12'h004, 1, 9'h012, 12'h002, 1, 1);
    vt[6]  = mk(0, 1, 1, 12'h005, 1, 9'h013, 12'h003, 1, 1);
    vt[7]  = mk(0, 0, 1, 12'h006, 1, 9'h014, 12'h004, 1, 1);
    vt[8]  = mk(0, 0, 1, 12'h007, 1, 9'h014, 12'h004, 1, 2);
    vt[9]  = mk(0, 0, 0, 12'h008, 1, 9'h014, 12'h004, 1, 3);
    vt[10] = mk(0, 0, 0, 12'h008, 1, 9'h014, 12'h004, 1, 4);
    vt[11] = mk(0, 0, 0, 12'h008, 1, 9'h014, 12'h004, 1, 4);
    vt[12] = mk(0, 1, 1, 12'h008, 1, 9'h014, 12'h004, 1, 4);
    vt[13] = mk(0, 1, 1, 12'h009, 1, 9'h015, 12'h005, 1, 3);
    vt[14] = mk(0, 1, 1, 12'h00A, 1, 9'h016, 12'h006, 1, 3);

    reset = 1; start = 0; instr_ready = 0; redirect = 0; halt = 0;
    redirect_target = '0;
    cyc(); cyc();
    reset = 0;
    smp();
    chk("rst_req", {31'h0, imem_req}, 0);
    chk("rst_addr", {20'h0, imem_addr}, 0);
    chk("rst_valid", {31'h0, instr_valid}, 0);
    chk("rst_busy_done", {30'h0, busy, done}, 0);
    chk("rst_occ", {29'h0, occupancy}, 0);

    // Start-up, steady stream and back-pressure.
    for (int i = 0; i < 15; i++) begin
      cyc();
      start = vt[i].st; instr_ready = vt[i].rdy;
      smp();
      chk($sformatf("v%0d_req", i), {31'h0, imem_req}, {31'h0, vt[i].req});
      if (vt[i].req) chk($sformatf("v%0d_addr", i), {20'h0, imem_addr}, {20'h0, vt[i].addr});
      chk($sformatf("v%0d_valid", i), {31'h0, instr_valid}, {31'h0, vt[i].vld});
      chk($sformatf("v%0d_instr", i), {23'h0, instr}, {23'h0, vt[i].ins});
      chk($sformatf("v%0d_pc", i), {20'h0, instr_pc}, {20'h0, vt[i].pc});
      chk($sformatf("v%0d_busy", i), {31'h0, busy}, {31'h0, vt[i].bsy});
      chk($sformatf("v%0d_done", i), {31'h0, done}, 0);
      chk($sformatf("v%0d_occ", i), {29'h0, occupancy}, {29'h0, vt[i].occ});
    end

    // Redirect with three queued entries and one in flight.
    cyc(); instr_ready = 0; redirect = 1; redirect_target = 12'h123;
    smp();
    chk("redir_pre_occ", {29'h0, occupancy}, 3);
    chk("redir_req_low", {31'h0, imem_req}, 0);
    cyc(); redirect = 0;
    smp();
    chk("redir_valid_low", {31'h0, instr_valid}, 0);
    chk("redir_occ0", {29'h0, occupancy}, 0);
    chk("redir_req", {31'h0, imem_req}, 1);
    chk("redir_addr", {20'h0, imem_addr}, 12'h123);
    cyc();
    smp();
    chk("redir_addr2", {20'h0, imem_addr}, 12'h124);
    chk("redir_valid_low2", {31'h0, instr_valid}, 0);
    cyc(); instr_ready = 1;
    smp();
    chk("redir_head_valid", {31'h0, instr_valid}, 1);
    chk("redir_head_pc", {20'h0, instr_pc}, 12'h123);
    chk("redir_head_instr", {23'h0, instr}, 9'h133);

    // PC wrap at the top of the address space.
    cyc(); redirect = 1; redirect_target = 12'hFFE;
    smp();
    cyc(); redirect = 0;
    for (int i = 0; i < 4; i++) begin
      logic [11:0] ea;
      ea = 12'hFFE + 12'(i);
      if (i > 0) cyc();
      smp();
      chk($sformatf("wrap_req%0d", i), {31'h0, imem_req}, 1);
      chk($sformatf("wrap_addr%0d", i), {20'h0, imem_addr}, {20'h0, ea});
    end
    for (int i = 0; i < 4; i++) begin cyc(); smp(); end

    // Halt and redirect together on an accepted head.
    cyc(); halt = 1; redirect = 1; redirect_target = 12'h055;
    smp();
    chk("halt_pre_valid", {31'h0, instr_valid}, 1);
    cyc(); halt = 0; redirect = 0;
    smp();
    chk("halt_done", {31'h0, done}, 1);
    chk("halt_busy", {31'h0, busy}, 0);
    chk("halt_req", {31'h0, imem_req}, 0);
    chk("halt_valid", {31'h0, instr_valid}, 0);
    chk("halt_occ", {29'h0, occupancy}, 0);
    cyc(); redirect = 1; halt = 1;
    smp();
    chk("done_ignore_req", {31'h0, imem_req}, 0);
    cyc(); redirect = 0; halt = 0; start = 1;
    smp();
    chk("done_held", {31'h0, done}, 1);
    cyc(); start = 0;
    smp();
    chk("restart_done", {31'h0, done}, 0);
    chk("restart_busy", {31'h0, busy}, 1);
    chk("restart_req", {31'h0, imem_req}, 1);
    chk("restart_addr", {20'h0, imem_addr}, 0);
    cyc(); smp();
    cyc(); smp();
    chk("restart_head_pc", {20'h0, instr_pc}, 0);
    chk("restart_head_valid", {31'h0, instr_valid}, 1);

    // Reset in the middle of a run with two entries queued.
    instr_ready = 0;
    for (int i = 0; i < 10 && occupancy != 3'd2; i++) begin cyc(); smp(); end
    chk("pre_reset_occ2", {29'h0, occupancy}, 2);
    cyc(); reset = 1;
    cyc(); reset = 0;
    smp();
    chk("mrst_req", {31'h0, imem_req}, 0);
    chk("mrst_addr", {20'h0, imem_addr}, 0);
    chk("mrst_valid", {31'h0, instr_valid}, 0);
    chk("mrst_instr", {23'h0, instr}, 0);
    chk("mrst_pc", {20'h0, instr_pc}, 0);
    chk("mrst_busy_done", {30'h0, busy, done}, 0);
    chk("mrst_occ", {29'h0, occupancy}, 0);
    cyc(); smp();
    chk("mrst_idle_req", {31'h0, imem_req}, 0);
    cyc(); start = 1; instr_ready = 1;
    smp();
    cyc(); start = 0;
    smp();
    chk("mrst_restart_addr", {20'h0, imem_addr}, 0);
    cyc(); smp();
    chk("mrst_no_stale", {31'h0, instr_valid}, 0);
    cyc(); smp();
    chk("mrst_head_pc", {20'h0, instr_pc}, 0);
    chk("mrst_head_instr", {23'h0, instr}, 9'h010);
    for (int i = 0; i < 4; i++) begin cyc(); smp(); end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
